dmem_axi_responder: RTL and testbench
=====================================

// Module: dmem_axi_responder
// PURPOSE
//  AXI4-lite-style data-memory responder for the NPC LSU's dmem master port. Serves single-beat
//  reads (AR/R, with ID and RLAST) and writes (AW/W/B, byte strobes) from an internal word array.
//  Read and write channels are independent FSMs with parameterised latency. Out-of-range
//  addresses return SLVERR. Sits between the LSU/arbiter and simulation memory.
// PARAMETERS
//  ADDR_BASE    32'h8000_0000  byte address of word 0
//  DEPTH_WORDS  4096           number of 32-bit words in the array
//  RD_LAT       2              extra cycles between AR handshake and RVALID (0 allowed)
//  WR_LAT       1              extra cycles between AW+W complete and BVALID (0 allowed)
// PORTS
//  clk      in   1   clock
//  rst      in   1   reset: synchronous, active-high
//  arvalid  in   1   read address valid
//  arready  out  1   read address ready
//  araddr   in   32  read byte address (bits [1:0] ignored)
//  arid     in   4   read transaction ID
//  rvalid   out  1   read data valid
//  rready   in   1   read data ready
//  rdata    out  32  read data word
//  rresp    out  2   00 OKAY, 10 SLVERR
//  rid      out  4   echo of arid
//  rlast    out  1   1 whenever rvalid (single beat)
//  awvalid  in   1   write address valid
//  awready  out  1   write address ready
//  awaddr   in   32  write byte address (bits [1:0] ignored)
//  wvalid   in   1   write data valid
//  wready   out  1   write data ready
//  wdata    in   32  write data, byte lanes per wstrb
//  wstrb    in   4   byte enables, bit i -> wdata[8i+7:8i]
//  bvalid   out  1   write response valid
//  bready   in   1   write response ready
//  bresp    out  2   00 OKAY, 10 SLVERR
// BEHAVIOUR
//  Reset: arready=awready=wready=1 next cycle; rvalid=bvalid=rlast=0; rdata,rresp,rid,bresp=0.
//   Array contents not reset. Reset mid-transaction drops it; uncommitted write never lands.
//  Range: idx=(addr-ADDR_BASE)>>2; in range iff addr>=ADDR_BASE and idx<DEPTH_WORDS.
//  Read FSM R_IDLE->R_DELAY->R_RESP. arready=(state==R_IDLE).
//   AR fire: latch addr,arid; load cnt=RD_LAT; go R_DELAY (R_RESP directly if RD_LAT==0).
//   R_DELAY: cnt decrements each cycle; at cnt==0 register rdata/rresp and go R_RESP.
//   => AR handshake at edge T gives rvalid from edge T+RD_LAT+1.
//   R_RESP: rvalid=1, rlast=1, rid=latched id; rdata=mem[idx] (OKAY) or 0 (SLVERR).
//   rvalid/rdata/rresp/rid held stable until rready; on handshake -> R_IDLE (arready next cycle).
//  Write FSM W_IDLE->W_DELAY->W_RESP. In W_IDLE, AW and W are accepted independently,
//   in either order or the same cycle: awready=W_IDLE&&!aw_got, wready=W_IDLE&&!w_got.
//   Latch awaddr / wdata+wstrb on their handshakes; when both held, load cnt=WR_LAT, go W_DELAY.
//   At cnt==0: commit write (in range only; only strobed bytes change; wstrb=0 leaves memory
//   unchanged, OKAY) in the same edge bvalid rises; go W_RESP.
//   => last of AW/W handshake at edge T gives commit + bvalid at edge T+WR_LAT+1.
//   W_RESP: bvalid=1, bresp held until bready; on handshake clear aw_got/w_got, -> W_IDLE.
//  Read/write interaction: channels run concurrently. A read sampling the array on the same edge
//   as a write commit to that word returns the pre-write data.
//  No bursts, no outstanding-transaction pipelining: at most one read and one write in flight.
// TESTING
//  1 AW 0x8000_0010, W 0xDEADBEEF/1111 two cycles later -> bvalid 2 cycles after W fire, bresp 00;
//    then AR 0x8000_0010 arid=1 -> rvalid 3 cycles after AR fire, rdata DEADBEEF, rid 1, rlast 1.
//  2 W before AW, wstrb 0100 wdata 0x00AA0000 @0x8000_0012 -> readback 0xDEAABEEF.
//  3 Same-cycle AW+W, then AR 0x0000_1000 -> rresp 10, rdata 0; write @0x9000_0000 -> bresp 10,
//    no array change.
//  4 rready low 5 cycles in R_RESP -> rvalid/rdata/rid stable, arready 0 until handshake;
//    same for bvalid/bresp with bready low; awready/wready 0 until B handshake.
//  5 Read and write to same word commit same edge -> read returns old value, next read new value.
//  6 rst pulse in R_DELAY and in W_DELAY -> rvalid/bvalid 0, all readies 1, target word unchanged.

Source files
------------

// File: rtl/dmem_axi_responder.sv
// dmem_axi_responder: single-beat AXI4-lite-style data memory for the LSU dmem port.
// Independent read (AR/R) and write (AW/W/B) state machines, each with a programmable
// response latency, serving a word array. Addresses outside the array answer SLVERR.
module dmem_axi_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned RD_LAT      = 2,
    parameter int unsigned WR_LAT      = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    input  logic [3:0]  arid,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [3:0]  rid,
    output logic        rlast,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp
);

    localparam int IW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int RCW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;
    localparam int WCW = (WR_LAT > 0) ? $clog2(WR_LAT + 1) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_DELAY = 2'd1;
    localparam logic [1:0] R_RESP  = 2'd2;

    localparam logic [1:0] W_IDLE  = 2'd0;
    localparam logic [1:0] W_DELAY = 2'd1;
    localparam logic [1:0] W_RESP  = 2'd2;

    // An address below the base wraps to a huge offset, so both tests are kept explicit.
    function automatic logic addr_ok(input logic [31:0] a);
        return (a >= ADDR_BASE) && (((a - ADDR_BASE) >> 2) < 32'(DEPTH_WORDS));
    endfunction

    function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
        return IW'((a - ADDR_BASE) >> 2);
    endfunction

    logic [31:0] mem_q [DEPTH_WORDS];

    // ---------------- read channel ----------------
    logic [1:0]     rstate_q, rstate_d;
    logic [RCW-1:0] rcnt_q, rcnt_d;
    logic [31:0]    raddr_q;
    logic [31:0]    rdata_q;
    logic [1:0]     rresp_q;
    logic [3:0]     rid_q;
    logic           ar_fire;
    logic           rd_sample;
    logic [31:0]    rd_addr;

    assign arready = (rstate_q == R_IDLE);
    assign ar_fire = arvalid && arready;
    assign rvalid  = (rstate_q == R_RESP);
    assign rlast   = rvalid;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rid     = rid_q;

    // Read next-state: count down the latency, then sample the array once into the R registers.
    always_comb begin
        rstate_d  = rstate_q;
        rcnt_d    = rcnt_q;
        rd_sample = 1'b0;
        rd_addr   = raddr_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rcnt_d = RCW'(RD_LAT);
                    if (RD_LAT == 0) begin
                        rd_sample = 1'b1;
                        rd_addr   = araddr;
                        rstate_d  = R_RESP;
                    end else begin
                        rstate_d = R_DELAY;
                    end
                end
            end
            R_DELAY: begin
                if (rcnt_q == '0) begin
                    rd_sample = 1'b1;
                    rstate_d  = R_RESP;
                end else begin
                    rcnt_d = rcnt_q - RCW'(1);
                end
            end
            R_RESP: begin
                if (rready) rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read control and response registers; response fields stay put until the next sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            rstate_q <= R_IDLE;
            rcnt_q   <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
            rid_q    <= '0;
        end else begin
            rstate_q <= rstate_d;
            rcnt_q   <= rcnt_d;
            if (ar_fire) rid_q <= arid;
            if (rd_sample) begin
                // The array read sees pre-commit contents when a write lands on this same edge.
                rdata_q <= addr_ok(rd_addr) ? mem_q[word_idx(rd_addr)] : 32'h0;
                rresp_q <= addr_ok(rd_addr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // Read address latch (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (ar_fire) raddr_q <= araddr;
    end

    // ---------------- write channel ----------------
    logic [1:0]     wstate_q, wstate_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic           aw_got_q, aw_got_d;
    logic           w_got_q, w_got_d;
    logic [31:0]    waddr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic [1:0]     bresp_q;
    logic           aw_fire, w_fire;
    logic           aw_have, w_have;
    logic           wr_commit;
    logic [31:0]    cm_addr, cm_data;
    logic [3:0]     cm_strb;

    assign awready = (wstate_q == W_IDLE) && !aw_got_q;
    assign wready  = (wstate_q == W_IDLE) && !w_got_q;
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign aw_have = aw_got_q || aw_fire;
    assign w_have  = w_got_q || w_fire;
    assign bvalid  = (wstate_q == W_RESP);
    assign bresp   = bresp_q;

    // Write next-state: collect AW and W in any order, wait the latency, commit once.
    always_comb begin
        wstate_d  = wstate_q;
        wcnt_d    = wcnt_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        wr_commit = 1'b0;
        cm_addr   = waddr_q;
        cm_data   = wdata_q;
        cm_strb   = wstrb_q;
        case (wstate_q)
            W_IDLE: begin
                aw_got_d = aw_have;
                w_got_d  = w_have;
                if (aw_have && w_have) begin
                    wcnt_d = WCW'(WR_LAT);
                    if (WR_LAT == 0) begin
                        // Zero latency commits on the completing handshake, so take live inputs.
                        wr_commit = 1'b1;
                        cm_addr   = aw_got_q ? waddr_q : awaddr;
                        cm_data   = w_got_q ? wdata_q : wdata;
                        cm_strb   = w_got_q ? wstrb_q : wstrb;
                        wstate_d  = W_RESP;
                    end else begin
                        wstate_d = W_DELAY;
                    end
                end
            end
            W_DELAY: begin
                if (wcnt_q == '0) begin
                    wr_commit = 1'b1;
                    wstate_d  = W_RESP;
                end else begin
                    wcnt_d = wcnt_q - WCW'(1);
                end
            end
            W_RESP: begin
                if (bready) begin
                    aw_got_d = 1'b0;
                    w_got_d  = 1'b0;
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write control and B response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate_q <= W_IDLE;
            wcnt_q   <= '0;
            aw_got_q <= 1'b0;
            w_got_q  <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            wcnt_q   <= wcnt_d;
            aw_got_q <= aw_got_d;
            w_got_q  <= w_got_d;
            if (wr_commit) bresp_q <= addr_ok(cm_addr) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    // Write address/data latches (data only, no reset needed).
    always_ff @(posedge clk) begin
        if (aw_fire) waddr_q <= awaddr;
        if (w_fire) begin
            wdata_q <= wdata;
            wstrb_q <= wstrb;
        end
    end

    // Array update: strobed bytes of an in-range word; a reset edge suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && wr_commit && addr_ok(cm_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (cm_strb[b]) mem_q[word_idx(cm_addr)][8*b +: 8] <= cm_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_axi_responder.sv
// Directed bench for dmem_axi_responder: stimulus pushes expected R/B beats into
// queues, a negedge monitor pops and compares on every handshake.
module tb_dmem_axi_responder;

    logic        clk;
    logic        rst;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid, bready;
    logic [1:0]  bresp;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] d;
        logic [1:0]  resp;
        logic [3:0]  id;
    } rexp_t;

    rexp_t      rq[$];
    logic [1:0] bq[$];

    dmem_axi_responder dut (
        .clk(clk), .rst(rst),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid), .rlast(rlast),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every R and B handshake against the queued expectation.
    always @(negedge clk) begin
        if (!rst && rvalid && rready) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL r_unexpected: got rdata 0x%0h rid %0d with no read outstanding", rdata, rid);
            end else begin
                rexp_t e;
                e = rq.pop_front();
                chk("r_beat", 64'({rdata, rresp, rid, rlast}), 64'({e.d, e.resp, e.id, 1'b1}));
            end
        end
        if (!rst && bvalid && bready) begin
            if (bq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got bresp %0b with no write outstanding", bresp);
            end else begin
                logic [1:0] eb;
                eb = bq.pop_front();
                chk("b_beat", 64'(bresp), 64'(eb));
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [3:0] id, output time tf);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = a; arid = id;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk); ok = arready;
            @(posedge clk);
        end
        tf = $time;
        #1 arvalid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL ar_timeout: got arready 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_r(output time tr);
        bit seen;
        seen = 1'b0;
        tr = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (rvalid) begin seen = 1'b1; tr = $time - 5; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL r_timeout: got rvalid 0 expected 1 within 50 cycles");
        end
    endtask

    task automatic wait_b(output time tb);
        bit seen;
        seen = 1'b0;
        tb = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bvalid) begin seen = 1'b1; tb = $time - 5; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL b_timeout: got bvalid 0 expected 1 within 50 cycles");
        end
    endtask

    // AW presented for one cycle at awc, W for one cycle at wc; tl = edge of the later handshake.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awc, input int wc, output time tl);
        int n;
        n = (awc > wc) ? awc : wc;
        for (int c = 0; c <= n; c++) begin
            @(posedge clk); #1;
            awvalid = (c == awc); wvalid = (c == wc);
            awaddr = a; wdata = d; wstrb = s;
        end
        @(posedge clk);
        tl = $time;
        #1 awvalid = 1'b0; wvalid = 1'b0;
    endtask

    initial begin
        time tf, tr, tl, tb;
        rst = 1'b1; rready = 1'b1; bready = 1'b1;
        arvalid = 1'b0; araddr = '0; arid = '0;
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_ctrl", 64'({arready, awready, wready, rvalid, bvalid, rlast}), 64'(6'b111000));
        chk("reset_data", 64'({rdata, rresp, rid, bresp}), 64'd0);

        // 1: AW then W two cycles later, read back
        bq.push_back(2'b00);
        do_write(32'h8000_0010, 32'hDEADBEEF, 4'b1111, 0, 2, tl);
        wait_b(tb);
        chk("t1_b_latency", 64'((tb - tl) / 10), 64'd2);
        idle(2);
        rq.push_back('{d: 32'hDEADBEEF, resp: 2'b00, id: 4'd1});
        send_ar(32'h8000_0010, 4'd1, tf);
        wait_r(tr);
        chk("t1_r_latency", 64'((tr - tf) / 10), 64'd3);
        idle(2);

        // 2: W before AW, single byte lane at an unaligned address
        bq.push_back(2'b00);
        do_write(32'h8000_0012, 32'h00AA_0000, 4'b0100, 2, 0, tl);
        wait_b(tb);
        chk("t2_b_latency", 64'((tb - tl) / 10), 64'd2);
        idle(2);
        rq.push_back('{d: 32'hDEAABEEF, resp: 2'b00, id: 4'd2});
        send_ar(32'h8000_0012, 4'd2, tf);
        wait_r(tr);
        idle(2);

        // 3: same-cycle AW+W, range boundaries, SLVERR paths leave the array alone
        bq.push_back(2'b00);
        do_write(32'h8000_0000, 32'hA5A5_A5A5, 4'b1111, 0, 0, tl);
        wait_b(tb);
        chk("t3_b_latency", 64'((tb - tl) / 10), 64'd2);
        idle(2);
        bq.push_back(2'b00);
        do_write(32'h8000_3FFC, 32'hCAFE_F00D, 4'b1111, 0, 0, tl);
        wait_b(tb); idle(2);
        bq.push_back(2'b10);
        do_write(32'h9000_0000, 32'h1111_1111, 4'b1111, 0, 0, tl);
        wait_b(tb); idle(2);
        bq.push_back(2'b10);
        do_write(32'h7FFF_FFFC, 32'h2222_2222, 4'b1111, 1, 0, tl);
        wait_b(tb); idle(2);
        bq.push_back(2'b10);
        do_write(32'h8000_4000, 32'h4444_4444, 4'b1111, 0, 0, tl);
        wait_b(tb); idle(2);
        rq.push_back('{d: 32'hA5A5_A5A5, resp: 2'b00, id: 4'd3});
        send_ar(32'h8000_0000, 4'd3, tf); wait_r(tr); idle(2);
        rq.push_back('{d: 32'h0, resp: 2'b10, id: 4'd4});
        send_ar(32'h0000_1000, 4'd4, tf); wait_r(tr); idle(2);
        rq.push_back('{d: 32'h0, resp: 2'b10, id: 4'd5});
        send_ar(32'h8000_4000, 4'd5, tf); wait_r(tr); idle(2);
        rq.push_back('{d: 32'hCAFE_F00D, resp: 2'b00, id: 4'd6});
        send_ar(32'h8000_3FFC, 4'd6, tf); wait_r(tr); idle(2);

        // 4: back-pressure on R and on B
        rready = 1'b0;
        rq.push_back('{d: 32'hDEAABEEF, resp: 2'b00, id: 4'd7});
        send_ar(32'h8000_0010, 4'd7, tf);
        wait_r(tr);
        chk("t4_r_latency", 64'((tr - tf) / 10), 64'd3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_r_hold", 64'({rvalid, rdata, rid, rresp, arready}),
                64'({1'b1, 32'hDEAABEEF, 4'd7, 2'b00, 1'b0}));
        end
        @(posedge clk); #1 rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_r_release", 64'({rvalid, arready}), 64'(2'b01));
        idle(1);

        bready = 1'b0;
        bq.push_back(2'b00);
        do_write(32'h8000_0024, 32'h0BAD_F00D, 4'b1111, 0, 0, tl);
        wait_b(tb);
        chk("t4_b_latency", 64'((tb - tl) / 10), 64'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_b_hold", 64'({bvalid, bresp, awready, wready}), 64'(5'b10000));
        end
        @(posedge clk); #1 bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("t4_b_release", 64'({bvalid, awready, wready}), 64'(3'b011));
        idle(1);

        // 5: read sample and write commit on the same edge
        bq.push_back(2'b00);
        do_write(32'h8000_0030, 32'h1111_1111, 4'b1111, 0, 0, tl);
        wait_b(tb); idle(2);
        rq.push_back('{d: 32'h1111_1111, resp: 2'b00, id: 4'd8});
        bq.push_back(2'b00);
        @(posedge clk); #1;
        arvalid = 1'b1; araddr = 32'h8000_0030; arid = 4'd8;
        @(posedge clk); #1;
        arvalid = 1'b0;
        awvalid = 1'b1; awaddr = 32'h8000_0030;
        wvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'b1111;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        idle(8);
        rq.push_back('{d: 32'h2222_2222, resp: 2'b00, id: 4'd9});
        send_ar(32'h8000_0030, 4'd9, tf); wait_r(tr); idle(2);

        // 6: reset pulse inside R_DELAY and inside W_DELAY
        send_ar(32'h8000_0030, 4'd10, tf);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_rdelay", 64'({rvalid, bvalid, arready, awready, wready}), 64'(5'b00111));
        idle(6);
        do_write(32'h8000_0030, 32'h3333_3333, 4'b1111, 0, 0, tl);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_in_wdelay", 64'({rvalid, bvalid, arready, awready, wready}), 64'(5'b00111));
        idle(6);
        rq.push_back('{d: 32'h2222_2222, resp: 2'b00, id: 4'd11});
        send_ar(32'h8000_0030, 4'd11, tf); wait_r(tr); idle(2);

        // Drain
        for (int i = 0; i < 20 && (rq.size() != 0 || bq.size() != 0); i++) @(posedge clk);
        chk("r_queue_drained", 64'(rq.size()), 64'd0);
        chk("b_queue_drained", 64'(bq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
